// File: rtl/mem_wb_ext.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_ext
// Purpose  : MEM->WB pipeline register with per-channel write sanitising.
//            Each clock edge takes one action: BUBBLE, HOLD or LOAD.
//            - BUBBLE: flush, or this stage stalled while the next is not.
//            - HOLD:   this stage and the next are both stalled.
//            - LOAD:   all other cases.
//            On LOAD, channels writing address 0 lose their enable. When
//            several enabled channels write the same nonzero address, only
//            the highest-index channel keeps its enable. An invalid bundle
//            loads with every enable cleared.
//            Retire and bubble counters count LOADs and BUBBLEs.
// Ports    : clk, rst (async, active high)
//            stall[STALL_W], flush
//            mem_valid_i, mem_waddr_i, mem_we_i, mem_wdata_i      (in)
//            mem_hilo_we_i, mem_hi_i, mem_lo_i                    (in)
//            wb_waddr_o, wb_we_o, wb_wdata_o                      (out)
//            wb_hilo_we_o, wb_hi_o, wb_lo_o                       (out)
//            wb_valid_o, wb_conflict_o                            (out)
//            retire_cnt_o, bubble_cnt_o                           (out)
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_ext #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int CH        = 2,
    parameter int STALL_W   = 6,
    parameter int STAGE_IDX = 4,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [STALL_W-1:0]   stall,
    input  logic                 flush,
    input  logic                 mem_valid_i,
    input  logic [CH*ADDR_W-1:0] mem_waddr_i,
    input  logic [CH-1:0]        mem_we_i,
    input  logic [CH*DATA_W-1:0] mem_wdata_i,
    input  logic                 mem_hilo_we_i,
    input  logic [DATA_W-1:0]    mem_hi_i,
    input  logic [DATA_W-1:0]    mem_lo_i,
    output logic [CH*ADDR_W-1:0] wb_waddr_o,
    output logic [CH-1:0]        wb_we_o,
    output logic [CH*DATA_W-1:0] wb_wdata_o,
    output logic                 wb_hilo_we_o,
    output logic [DATA_W-1:0]    wb_hi_o,
    output logic [DATA_W-1:0]    wb_lo_o,
    output logic                 wb_valid_o,
    output logic                 wb_conflict_o,
    output logic [CNT_W-1:0]     retire_cnt_o,
    output logic [CNT_W-1:0]     bubble_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Only two bits of the stall vector matter to this stage.
    logic unused_stall;
    assign unused_stall = ^stall;

    logic do_bubble;
    logic do_hold;

    // Flush wins over any stall combination.
    assign do_bubble = flush | (stall[STAGE_IDX] & ~stall[STAGE_IDX+1]);
    assign do_hold   = ~flush & stall[STAGE_IDX] & stall[STAGE_IDX+1];

    logic [CH-1:0] we_eff;
    logic          conflict;

    // A channel keeps its enable only if its address is nonzero and no
    // higher-index enabled channel targets the same address. Address 0
    // never conflicts because those channels are already disabled.
    always_comb begin
        we_eff   = '0;
        conflict = 1'b0;
        for (int k = 0; k < CH; k++) begin
            if (mem_we_i[k] && (mem_waddr_i[k*ADDR_W +: ADDR_W] != '0)) begin
                we_eff[k] = 1'b1;
                for (int j = k + 1; j < CH; j++) begin
                    if (mem_we_i[j] &&
                        (mem_waddr_i[j*ADDR_W +: ADDR_W] == mem_waddr_i[k*ADDR_W +: ADDR_W])) begin
                        we_eff[k] = 1'b0;
                        conflict  = 1'b1;
                    end
                end
            end
        end
        // An invalid bundle carries no writes, so nothing was resolved.
        if (!mem_valid_i) begin
            we_eff   = '0;
            conflict = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_waddr_o    <= '0;
            wb_we_o       <= '0;
            wb_wdata_o    <= '0;
            wb_hilo_we_o  <= 1'b0;
            wb_hi_o       <= '0;
            wb_lo_o       <= '0;
            wb_valid_o    <= 1'b0;
            wb_conflict_o <= 1'b0;
            retire_cnt_o  <= '0;
            bubble_cnt_o  <= '0;
        end else if (do_bubble) begin
            wb_waddr_o    <= '0;
            wb_we_o       <= '0;
            wb_wdata_o    <= '0;
            wb_hilo_we_o  <= 1'b0;
            wb_hi_o       <= '0;
            wb_lo_o       <= '0;
            wb_valid_o    <= 1'b0;
            wb_conflict_o <= 1'b0;
            if (bubble_cnt_o != '1) begin
                bubble_cnt_o <= bubble_cnt_o + CNT_ONE;
            end
        end else if (!do_hold) begin
            wb_waddr_o    <= mem_waddr_i;
            wb_we_o       <= we_eff;
            wb_wdata_o    <= mem_wdata_i;
            wb_hilo_we_o  <= mem_hilo_we_i & mem_valid_i;
            wb_hi_o       <= mem_hi_i;
            wb_lo_o       <= mem_lo_i;
            wb_valid_o    <= mem_valid_i;
            wb_conflict_o <= conflict;
            if (mem_valid_i) begin
                retire_cnt_o <= retire_cnt_o + CNT_ONE;
            end else if (bubble_cnt_o != '1) begin
                bubble_cnt_o <= bubble_cnt_o + CNT_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_ext.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_wb_ext
// Purpose  : Directed self-checking bench for mem_wb_ext (CH=2, CNT_W=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_wb_ext;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CH     = 2;
    localparam int CNT_W  = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [5:0]           stall = '0;
    logic                 flush = 1'b0;
    logic                 mem_valid_i = 1'b0;
    logic [CH*ADDR_W-1:0] mem_waddr_i = '0;
    logic [CH-1:0]        mem_we_i = '0;
    logic [CH*DATA_W-1:0] mem_wdata_i = '0;
    logic                 mem_hilo_we_i = 1'b0;
    logic [DATA_W-1:0]    mem_hi_i = '0;
    logic [DATA_W-1:0]    mem_lo_i = '0;
    logic [CH*ADDR_W-1:0] wb_waddr_o;
    logic [CH-1:0]        wb_we_o;
    logic [CH*DATA_W-1:0] wb_wdata_o;
    logic                 wb_hilo_we_o;
    logic [DATA_W-1:0]    wb_hi_o;
    logic [DATA_W-1:0]    wb_lo_o;
    logic                 wb_valid_o;
    logic                 wb_conflict_o;
    logic [CNT_W-1:0]     retire_cnt_o;
    logic [CNT_W-1:0]     bubble_cnt_o;

    int errors = 0;
    int checks = 0;

    mem_wb_ext #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CH(CH),
        .STALL_W(6), .STAGE_IDX(4), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_valid_i(mem_valid_i), .mem_waddr_i(mem_waddr_i),
        .mem_we_i(mem_we_i), .mem_wdata_i(mem_wdata_i),
        .mem_hilo_we_i(mem_hilo_we_i), .mem_hi_i(mem_hi_i), .mem_lo_i(mem_lo_i),
        .wb_waddr_o(wb_waddr_o), .wb_we_o(wb_we_o), .wb_wdata_o(wb_wdata_o),
        .wb_hilo_we_o(wb_hilo_we_o), .wb_hi_o(wb_hi_o), .wb_lo_o(wb_lo_o),
        .wb_valid_o(wb_valid_o), .wb_conflict_o(wb_conflict_o),
        .retire_cnt_o(retire_cnt_o), .bubble_cnt_o(bubble_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the active edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero_bundle(input string tag);
        chk({tag, ".waddr"}, 64'(wb_waddr_o), 64'h0);
        chk({tag, ".we"},    64'(wb_we_o),    64'h0);
        chk({tag, ".wdata"}, 64'(wb_wdata_o), 64'h0);
        chk({tag, ".hilo"},  {wb_hilo_we_o, wb_hi_o[30:0], wb_lo_o}, 64'h0);
        chk({tag, ".valid"}, 64'(wb_valid_o), 64'h0);
        chk({tag, ".confl"}, 64'(wb_conflict_o), 64'h0);
    endtask

    task automatic drive(input logic v, input logic [9:0] a, input logic [1:0] we,
                         input logic [63:0] d);
        mem_valid_i = v;
        mem_waddr_i = a;
        mem_we_i    = we;
        mem_wdata_i = d;
    endtask

    initial begin
        // Power-on reset, observed before any clock edge.
        #1 rst = 1'b1;
        #1;
        chk_zero_bundle("por");
        chk("por.retire", 64'(retire_cnt_o), 64'h0);
        chk("por.bubble", 64'(bubble_cnt_o), 64'h0);
        tick();
        rst = 1'b0;

        // Plain load.
        drive(1'b1, {5'd7, 5'd3}, 2'b11, {32'h22, 32'h11});
        tick();
        chk("load.waddr", 64'(wb_waddr_o), 64'({5'd7, 5'd3}));
        chk("load.we",    64'(wb_we_o),    64'h3);
        chk("load.wdata", 64'(wb_wdata_o), {32'h22, 32'h11});
        chk("load.valid", 64'(wb_valid_o), 64'h1);
        chk("load.confl", 64'(wb_conflict_o), 64'h0);
        chk("load.retire", 64'(retire_cnt_o), 64'h1);
        chk("load.bubble", 64'(bubble_cnt_o), 64'h0);

        // Same-address conflict: only channel 1 keeps its enable.
        drive(1'b1, {5'd5, 5'd5}, 2'b11, {32'hB, 32'hA});
        tick();
        chk("confl.we",     64'(wb_we_o),       64'h2);
        chk("confl.flag",   64'(wb_conflict_o), 64'h1);
        chk("confl.wdata",  64'(wb_wdata_o),    {32'hB, 32'hA});
        chk("confl.retire", 64'(retire_cnt_o),  64'h2);

        // Channel 0 to address 0: enable dropped, address/data still load.
        drive(1'b1, {5'd7, 5'd0}, 2'b11, {32'h66, 32'h55});
        tick();
        chk("zaddr.we",    64'(wb_we_o),       64'h2);
        chk("zaddr.waddr", 64'(wb_waddr_o),    64'({5'd7, 5'd0}));
        chk("zaddr.flag",  64'(wb_conflict_o), 64'h0);
        chk("zaddr.retire", 64'(retire_cnt_o), 64'h3);

        // Own stage stalled, next free: bubble.
        stall = 6'b010000;
        tick();
        chk_zero_bundle("stbub");
        chk("stbub.bubble", 64'(bubble_cnt_o), 64'h1);
        chk("stbub.retire", 64'(retire_cnt_o), 64'h3);

        // HI/LO load combined with a conflict, to be held afterwards.
        stall = 6'b000000;
        drive(1'b1, {5'd1, 5'd1}, 2'b11, {32'h44, 32'h33});
        mem_hilo_we_i = 1'b1;
        mem_hi_i = 32'hDEAD;
        mem_lo_i = 32'hBEEF;
        tick();
        chk("hilo.we",   64'(wb_hilo_we_o), 64'h1);
        chk("hilo.hi",   64'(wb_hi_o),      64'hDEAD);
        chk("hilo.lo",   64'(wb_lo_o),      64'hBEEF);
        chk("hilo.chwe", 64'(wb_we_o),      64'h2);
        chk("hilo.flag", 64'(wb_conflict_o), 64'h1);
        chk("hilo.retire", 64'(retire_cnt_o), 64'h4);

        // Hold three cycles with different inputs: everything frozen.
        stall = 6'b110000;
        drive(1'b1, {5'd9, 5'd8}, 2'b01, {32'h77, 32'h88});
        mem_hi_i = 32'h1234;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold.waddr", 64'(wb_waddr_o), 64'({5'd1, 5'd1}));
            chk("hold.we",    64'(wb_we_o),    64'h2);
            chk("hold.wdata", 64'(wb_wdata_o), {32'h44, 32'h33});
            chk("hold.hi",    64'(wb_hi_o),    64'hDEAD);
            chk("hold.flag",  64'(wb_conflict_o), 64'h1);
            chk("hold.cnts",  64'({retire_cnt_o, bubble_cnt_o}), 64'h41);
        end

        // Flush together with a hold stall: bubble wins.
        flush = 1'b1;
        tick();
        chk_zero_bundle("flush");
        chk("flush.cnts", 64'({retire_cnt_o, bubble_cnt_o}), 64'h42);

        // HI/LO with valid=0: enables forced off, data still loads.
        flush = 1'b0;
        stall = 6'b000000;
        drive(1'b0, {5'd3, 5'd4}, 2'b11, {32'h2, 32'h1});
        mem_hilo_we_i = 1'b1;
        mem_hi_i = 32'hDEAD;
        mem_lo_i = 32'hBEEF;
        tick();
        chk("inv.hilowe", 64'(wb_hilo_we_o), 64'h0);
        chk("inv.we",     64'(wb_we_o),      64'h0);
        chk("inv.valid",  64'(wb_valid_o),   64'h0);
        chk("inv.hi",     64'(wb_hi_o),      64'hDEAD);
        chk("inv.cnts",   64'({retire_cnt_o, bubble_cnt_o}), 64'h43);

        // Valid load, then async reset raised mid-hold between edges.
        mem_hilo_we_i = 1'b0;
        drive(1'b1, {5'd2, 5'd6}, 2'b11, {32'hC, 32'hD});
        tick();
        chk("pre.retire", 64'(retire_cnt_o), 64'h5);
        stall = 6'b110000;
        #2 rst = 1'b1;
        #1;
        chk_zero_bundle("arst");
        chk("arst.cnts", 64'({retire_cnt_o, bubble_cnt_o}), 64'h00);
        tick();
        rst = 1'b0;
        stall = 6'b000000;
        drive(1'b1, {5'd9, 5'd8}, 2'b11, {32'h99, 32'h98});
        tick();
        chk("post.waddr",  64'(wb_waddr_o),   64'({5'd9, 5'd8}));
        chk("post.valid",  64'(wb_valid_o),   64'h1);
        chk("post.retire", 64'(retire_cnt_o), 64'h1);

        // 16 more valid loads: 17 total wraps a 4-bit counter to 1.
        for (int i = 0; i < 16; i++) tick();
        chk("wrap.retire", 64'(retire_cnt_o), 64'h1);
        chk("wrap.bubble", 64'(bubble_cnt_o), 64'h0);

        // 20 bubbles saturate the 4-bit bubble counter at 15.
        flush = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("sat.bubble", 64'(bubble_cnt_o), 64'hF);
        chk("sat.retire", 64'(retire_cnt_o), 64'h1);
        flush = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_wb_ext.md
MEM_WB_EXT -- requirements
Module: mem_wb_ext

Interface
REQ-001 Parameter DATA_W, 32, register-write data width.
REQ-002 Parameter ADDR_W, 5, register address width.
REQ-003 Parameter CH, 2, number of register write channels (1..4).
REQ-004 Parameter STALL_W, 6, stall bus width.
REQ-005 Parameter STAGE_IDX, 4, stall bit owned by this stage; STAGE_IDX+1 SHALL be < STALL_W.
REQ-006 Parameter CNT_W, 32, performance counter width.
REQ-007 clk  in  1  clock; all state updates on rising edge.
REQ-008 rst  in  1  asynchronous active-high reset.
REQ-009 stall  in  STALL_W  pipeline stall vector; bit=1 means stop.
REQ-010 flush  in  1  discard the incoming bundle and load a bubble.
REQ-011 mem_valid_i  in  1  incoming bundle holds a real instruction.
REQ-012 mem_waddr_i  in  CH*ADDR_W  packed write addresses; channel k at [k*ADDR_W +: ADDR_W].
REQ-013 mem_we_i  in  CH  per-channel write enables.
REQ-014 mem_wdata_i  in  CH*DATA_W  packed write data.
REQ-015 mem_hilo_we_i, mem_hi_i, mem_lo_i  in  1/DATA_W/DATA_W  HI/LO write bundle.
REQ-016 wb_waddr_o, wb_we_o, wb_wdata_o  out  matching the input widths  registered per-channel write bundle.
REQ-017 wb_hilo_we_o, wb_hi_o, wb_lo_o  out  1/DATA_W/DATA_W  registered HI/LO bundle.
REQ-018 wb_valid_o  out  1  registered bundle is a real instruction.
REQ-019 wb_conflict_o  out  1  one-cycle flag: a same-address write conflict was resolved on the last load.
REQ-020 retire_cnt_o, bubble_cnt_o  out  CNT_W  performance counters.

Function
REQ-021 Each edge SHALL take exactly one action, in priority order: flush -> BUBBLE; stall[STAGE_IDX]=1 and stall[STAGE_IDX+1]=0 -> BUBBLE; stall[STAGE_IDX]=1 and stall[STAGE_IDX+1]=1 -> HOLD; otherwise -> LOAD.
REQ-022 BUBBLE SHALL set every wb_waddr to 0, every wb_we to 0, every wb_wdata to 0, wb_hilo_we, wb_hi and wb_lo to 0, and wb_valid_o to 0.
REQ-023 HOLD SHALL keep every registered output unchanged, including wb_conflict_o.
REQ-024 On LOAD, every output bundle SHALL take the corresponding input with one-cycle latency, subject to REQ-025 to REQ-027.
REQ-025 On LOAD, a channel whose address is 0 SHALL have its wb_we forced to 0; its address and data still load.
REQ-026 On LOAD, if two or more enabled channels share a nonzero address, only the highest-index channel SHALL keep we=1; lower-index ones get we=0.
REQ-027 wb_conflict_o SHALL be 1 for a LOAD in which REQ-026 cleared at least one enable, and 0 on every other LOAD or BUBBLE.
REQ-028 On LOAD with mem_valid_i=0, all enables (per-channel and HI/LO) SHALL be forced to 0, and wb_valid_o SHALL be 0.
REQ-029 retire_cnt_o SHALL increment by 1 on each LOAD with mem_valid_i=1 and wrap from all-ones to 0.
REQ-030 bubble_cnt_o SHALL increment on each BUBBLE and on each LOAD with mem_valid_i=0, and saturate at all-ones.
REQ-031 HOLD SHALL change neither counter.
REQ-032 Flush asserted together with any stall SHALL yield BUBBLE (flush wins).

Reset
REQ-033 While rst=1, all outputs SHALL be 0 immediately, without waiting for clk, including both counters.
REQ-034 rst asserted mid-HOLD SHALL discard the held bundle; the first edge after release SHALL apply REQ-021 normally.

Verification
REQ-035 Async reset: raise rst between edges with the outputs loaded -> all outputs read 0 before the next edge; counters read 0.
REQ-036 Plain load, CH=2: ch0 = (addr 3, we 1, 0x11), ch1 = (addr 7, we 1, 0x22), valid=1, no stall -> next cycle the outputs match, wb_valid_o=1, retire_cnt=1.
REQ-037 Conflict: both channels addr 5, we=1, data 0xA/0xB -> wb_we = 2'b10, wb_conflict_o=1 for one cycle; ch0 with addr 0 and we=1 -> its wb_we=0.
REQ-038 Stall: stall=6'b010000 -> bubble loaded and bubble_cnt+1; stall=6'b110000 for 3 cycles -> outputs frozen for 3 cycles and counters unchanged; flush together with stall=6'b110000 -> bubble.
REQ-039 Counter limits, CNT_W=4: 17 valid loads -> retire_cnt=1 (wrapped); 20 bubbles -> bubble_cnt=15 (saturated).
REQ-040 HI/LO: hilo_we=1, hi=0xDEAD, lo=0xBEEF, valid=1 -> registered next cycle; the same stimulus with valid=0 -> wb_hilo_we_o=0.
